// File: rtl/dbg_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory controller.
package dbg_ocimem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdReq,
    StWrReq,
    StDone
  } state_e;

  // One-hot command granted by the strobe arbiter.
  typedef enum logic [2:0] {
    CmdNone  = 3'b000,
    CmdWrite = 3'b001,
    CmdLoad  = 3'b010,
    CmdRead  = 3'b100
  } cmd_e;

  localparam int unsigned JDO_W        = 38;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned JDO_RD_BIT   = 35;
  localparam int unsigned JDO_CLR_BIT  = 36;
  localparam int unsigned JDO_DATA_LSB = 3;
  localparam int unsigned JDO_ADDR_LSB = 2;
  localparam int unsigned TIMEOUT_W    = 8;

endpackage

// File: rtl/dbg_ocimem_ctrl_if.sv
// Word-wide request/acknowledge port between the OCI controller and the debug RAM.
interface dbg_ocimem_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/dbg_cmd_arbiter.sv
// Picks one debug-memory command per cycle (write > address load > stream read) and
// flags any strobe that has to be thrown away.
module dbg_cmd_arbiter
  import dbg_ocimem_pkg::*;
(
  input  logic take_b_i,
  input  logic take_a_i,
  input  logic take_na_i,
  input  logic busy_i,
  output cmd_e cmd_o,
  output logic drop_o
);

  always_comb begin
    cmd_o  = CmdNone;
    drop_o = 1'b0;
    if (busy_i) begin
      drop_o = take_b_i | take_a_i | take_na_i;
    end else begin
      if (take_b_i) begin
        cmd_o = CmdWrite;
      end else if (take_a_i) begin
        cmd_o = CmdLoad;
      end else if (take_na_i) begin
        cmd_o = CmdRead;
      end
      // Anything below the winning strobe is discarded.
      drop_o = (take_b_i & (take_a_i | take_na_i)) | (take_a_i & take_na_i);
    end
  end

endmodule

// File: rtl/dbg_ocimem_ctrl.sv
// Sysclk-side OCI memory controller: turns JTAG debug-slave strobes into word accesses
// on the debug RAM and maintains MonAReg/MonDReg plus the ready/error status.
module dbg_ocimem_ctrl
  import dbg_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [JDO_W-1:0]         jdo,
  input  logic                     take_action_ocimem_a,
  input  logic                     take_action_ocimem_b,
  input  logic                     take_no_action_ocimem_a,
  dbg_ocimem_ctrl_if.master        mem,
  output logic [ADDR_W-1:0]        MonAReg,
  output logic [DATA_W-1:0]        MonDReg,
  output logic                     monitor_ready,
  output logic                     monitor_error,
  output logic                     busy
);

  state_e                state_q, state_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  to_q, to_d;

  cmd_e                  cmd;
  logic                  drop;
  logic                  clr_err;
  logic                  timeout_hit;

  logic                  unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1], jdo[1:0]};

  assign busy = (state_q != StIdle);

  dbg_cmd_arbiter u_arb (
    .take_b_i  (take_action_ocimem_b),
    .take_a_i  (take_action_ocimem_a),
    .take_na_i (take_no_action_ocimem_a),
    .busy_i    (busy),
    .cmd_o     (cmd),
    .drop_o    (drop)
  );

  assign cnt_inc = cnt_q + TIMEOUT_W'(1);
  assign clr_err = (cmd == CmdLoad) && jdo[JDO_CLR_BIT];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wdata_d     = wdata_q;
    ready_d     = ready_q;
    to_d        = to_q;
    timeout_hit = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        unique case (cmd)
          CmdWrite: begin
            wdata_d = jdo[JDO_DATA_LSB +: DATA_W];
            ready_d = 1'b0;
            state_d = StWrReq;
          end
          CmdLoad: begin
            addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
            if (jdo[JDO_RD_BIT]) begin
              ready_d = 1'b0;
              state_d = StRdReq;
            end else begin
              ready_d = 1'b1;
            end
          end
          CmdRead: begin
            ready_d = 1'b0;
            state_d = StRdReq;
          end
          default: ;
        endcase
      end
      StRdReq, StWrReq: begin
        // An ack on the final allowed cycle still counts as success.
        if (mem.mem_ack) begin
          data_d  = (state_q == StWrReq) ? wdata_q : mem.mem_rdata;
          to_d    = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else if (cnt_inc == TIMEOUT_W'(TIMEOUT)) begin
          timeout_hit = 1'b1;
          to_d        = 1'b1;
          cnt_d       = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        addr_d  = addr_q + ADDR_W'(1);
        ready_d = ~to_q;
        to_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The clear is applied first so a same-cycle drop or timeout still leaves the flag set.
  assign err_d = (err_q & ~clr_err) | drop | timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign mem.mem_req   = (state_q == StRdReq) || (state_q == StWrReq);
  assign mem.mem_we    = (state_q == StWrReq);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign MonAReg       = addr_q;
  assign MonDReg       = data_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_dbg_ocimem_ctrl.sv
// Bench for dbg_ocimem_ctrl: directed vector table, hand-written corner sequences and a
// randomized command stream checked against a transaction-level model.
module tb_dbg_ocimem_ctrl;

  localparam int TO      = 4;
  localparam int KLoad   = 0;
  localparam int KLoadRd = 1;
  localparam int KWrite  = 2;
  localparam int KRead   = 3;

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          clr;
    int          delay;      // cycles before ack; -1 = never ack
    logic [31:0] rdata;
    logic [7:0]  exp_maddr;
    logic        exp_we;
    logic [7:0]  exp_a;
    logic [31:0] exp_d;
    logic        exp_rdy;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [7:0]  mon_a;
  logic [31:0] mon_d;
  logic        monitor_ready, monitor_error, busy;

  int total = 0;
  int bad   = 0;

  vec_t tbl[8];

  dbg_ocimem_ctrl_if #(.ADDR_W(8)) mif ();

  dbg_ocimem_ctrl #(
    .ADDR_W  (8),
    .TIMEOUT (TO)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .mem                     (mif),
    .MonAReg                 (mon_a),
    .MonDReg                 (mon_d),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issues one command and plays the memory side; returns what the port showed.
  task automatic do_cmd(input int kind, input logic [7:0] addr, input logic [31:0] data,
                        input bit clr, input int delay, input logic [31:0] rdata,
                        output logic [7:0] o_maddr, output logic o_we,
                        output logic [31:0] o_wdata, output int o_cycles,
                        output logic o_rdy_mid, output logic o_busy_done,
                        output logic o_stable);
    logic [37:0] w;
    w = '0;
    o_maddr = '0; o_we = 1'b0; o_wdata = '0; o_cycles = 0;
    o_rdy_mid = 1'b0; o_busy_done = 1'b0; o_stable = 1'b1;
    if (kind == KWrite) begin
      w[34:3] = data;
      take_b  = 1'b1;
    end else if (kind == KRead) begin
      take_na = 1'b1;
    end else begin
      w[9:2]  = addr;
      w[35]   = (kind == KLoadRd);
      w[36]   = clr;
      take_a  = 1'b1;
    end
    jdo = w;
    tick();
    take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    if (kind != KLoad) begin
      o_maddr   = mif.mem_addr;
      o_we      = mif.mem_we;
      o_wdata   = mif.mem_wdata;
      o_rdy_mid = monitor_ready;
      while (mif.mem_req && o_cycles < 20) begin
        if (mif.mem_addr !== o_maddr || mif.mem_we !== o_we) o_stable = 1'b0;
        if (o_cycles == delay) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rdata;
        end
        tick();
        mif.mem_ack = 1'b0;
        o_cycles++;
      end
      o_busy_done = busy;
      tick();
    end
  endtask

  logic [7:0]  o_maddr;
  logic        o_we;
  logic [31:0] o_wdata;
  int          o_cycles;
  logic        o_rdy_mid, o_busy_done, o_stable;

  int          r_kind, r_delay;
  logic [7:0]  r_addr;
  logic [31:0] r_data, r_rdata;
  bit          r_clr;
  logic [7:0]  m_a;
  logic [31:0] m_d, m_wd;
  logic        m_rdy, m_err;

  initial begin
    reset = 1'b1; jdo = '0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;

    tbl[0] = '{KLoadRd, 8'h10, 32'h0,        1'b0,  3, 32'hDEADBEEF,
               8'h10, 1'b0, 8'h11, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[1] = '{KWrite,  8'h00, 32'h12345678, 1'b0,  1, 32'h0,
               8'h11, 1'b1, 8'h12, 32'h12345678, 1'b1, 1'b0};
    tbl[2] = '{KLoad,   8'hFF, 32'h0,        1'b0,  0, 32'h0,
               8'h00, 1'b0, 8'hFF, 32'h12345678, 1'b1, 1'b0};
    tbl[3] = '{KRead,   8'h00, 32'h0,        1'b0,  0, 32'hCAFEF00D,
               8'hFF, 1'b0, 8'h00, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[4] = '{KRead,   8'h00, 32'h0,        1'b0, -1, 32'h11111111,
               8'h00, 1'b0, 8'h01, 32'hCAFEF00D, 1'b0, 1'b1};
    tbl[5] = '{KLoad,   8'h40, 32'h0,        1'b1,  0, 32'h0,
               8'h00, 1'b0, 8'h40, 32'hCAFEF00D, 1'b1, 1'b0};
    tbl[6] = '{KLoadRd, 8'h7F, 32'h0,        1'b0,  2, 32'h0BADF00D,
               8'h7F, 1'b0, 8'h80, 32'h0BADF00D, 1'b1, 1'b0};
    tbl[7] = '{KWrite,  8'h00, 32'hA5A5A5A5, 1'b0,  0, 32'h0,
               8'h80, 1'b1, 8'h81, 32'hA5A5A5A5, 1'b1, 1'b0};

    repeat (2) tick();
    reset = 1'b0;
    check("rst_req",   32'(mif.mem_req),   32'h0);
    check("rst_addr",  32'(mif.mem_addr),  32'h0);
    check("rst_wdata", mif.mem_wdata,      32'h0);
    check("rst_a",     32'(mon_a),         32'h0);
    check("rst_d",     mon_d,              32'h0);
    check("rst_rdy",   32'(monitor_ready), 32'h0);
    check("rst_err",   32'(monitor_error), 32'h0);
    check("rst_busy",  32'(busy),          32'h0);

    for (int i = 0; i < 8; i++) begin
      do_cmd(tbl[i].kind, tbl[i].addr, tbl[i].data, tbl[i].clr, tbl[i].delay, tbl[i].rdata,
             o_maddr, o_we, o_wdata, o_cycles, o_rdy_mid, o_busy_done, o_stable);
      if (tbl[i].kind != KLoad) begin
        check($sformatf("v%0d_maddr", i), 32'(o_maddr), 32'(tbl[i].exp_maddr));
        check($sformatf("v%0d_we", i), 32'(o_we), 32'(tbl[i].exp_we));
        check($sformatf("v%0d_cycles", i), 32'(o_cycles),
              32'((tbl[i].delay < 0) ? TO : tbl[i].delay + 1));
        check($sformatf("v%0d_rdy_mid", i), 32'(o_rdy_mid), 32'h0);
        check($sformatf("v%0d_done", i), 32'(o_busy_done), 32'h1);
        check($sformatf("v%0d_stable", i), 32'(o_stable), 32'h1);
        if (tbl[i].kind == KWrite) check($sformatf("v%0d_wdata", i), o_wdata, tbl[i].data);
      end
      check($sformatf("v%0d_a", i), 32'(mon_a), 32'(tbl[i].exp_a));
      check($sformatf("v%0d_d", i), mon_d, tbl[i].exp_d);
      check($sformatf("v%0d_rdy", i), 32'(monitor_ready), 32'(tbl[i].exp_rdy));
      check($sformatf("v%0d_err", i), 32'(monitor_error), 32'(tbl[i].exp_err));
    end

    // Collision: write beats stream read, the read is dropped with an error.
    jdo = '0; jdo[34:3] = 32'h5A5A0001; take_b = 1'b1; take_na = 1'b1;
    tick();
    take_b = 1'b0; take_na = 1'b0;
    check("coll_we",   32'(mif.mem_we),    32'h1);
    check("coll_addr", 32'(mif.mem_addr),  32'h81);
    check("coll_err",  32'(monitor_error), 32'h1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF0000;
    tick();
    mif.mem_ack = 1'b0;
    check("coll_d", mon_d, 32'h5A5A0001);
    tick();
    check("coll_a",   32'(mon_a),         32'h82);
    check("coll_rdy", 32'(monitor_ready), 32'h1);

    do_cmd(KLoad, 8'h20, 32'h0, 1'b1, 0, 32'h0,
           o_maddr, o_we, o_wdata, o_cycles, o_rdy_mid, o_busy_done, o_stable);
    check("clr_err", 32'(monitor_error), 32'h0);

    // A strobe while busy (even one carrying the clear bit) is dropped.
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    tick();
    jdo = '0; jdo[9:2] = 8'h33; jdo[35] = 1'b1; jdo[36] = 1'b1; take_a = 1'b1;
    tick();
    take_a = 1'b0;
    check("busy_err",  32'(monitor_error), 32'h1);
    check("busy_addr", 32'(mif.mem_addr),  32'h20);
    check("busy_req",  32'(mif.mem_req),   32'h1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h600DCAFE;
    tick();
    mif.mem_ack = 1'b0;
    tick();
    check("busy_a",   32'(mon_a),         32'h21);
    check("busy_d",   mon_d,              32'h600DCAFE);
    check("busy_rdy", 32'(monitor_ready), 32'h1);
    check("busy_err2", 32'(monitor_error), 32'h1);

    // Reset in the middle of a read, then a stale ack.
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    check("mid_req", 32'(mif.mem_req), 32'h1);
    reset = 1'b1;
    tick();
    check("mrst_req",   32'(mif.mem_req),   32'h0);
    check("mrst_a",     32'(mon_a),         32'h0);
    check("mrst_d",     mon_d,              32'h0);
    check("mrst_wdata", mif.mem_wdata,      32'h0);
    check("mrst_rdy",   32'(monitor_ready), 32'h0);
    check("mrst_err",   32'(monitor_error), 32'h0);
    check("mrst_busy",  32'(busy),          32'h0);
    reset = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
    tick();
    mif.mem_ack = 1'b0;
    check("late_d",    mon_d,        32'h0);
    check("late_busy", 32'(busy),    32'h0);
    check("late_req",  32'(mif.mem_req), 32'h0);

    // Randomized stream against a transaction-level model.
    m_a = '0; m_d = '0; m_wd = '0; m_rdy = 1'b0; m_err = 1'b0;
    for (int n = 0; n < 60; n++) begin
      r_kind  = int'($urandom_range(0, 3));
      r_addr  = 8'($urandom);
      r_data  = $urandom;
      r_rdata = $urandom;
      r_clr   = 1'($urandom_range(0, 1));
      r_delay = int'($urandom_range(0, 4));
      if (r_delay == 4) r_delay = -1;
      do_cmd(r_kind, r_addr, r_data, r_clr, r_delay, r_rdata,
             o_maddr, o_we, o_wdata, o_cycles, o_rdy_mid, o_busy_done, o_stable);
      if (r_kind == KLoad || r_kind == KLoadRd) begin
        m_a = r_addr;
        if (r_clr) m_err = 1'b0;
      end
      if (r_kind == KWrite) m_wd = r_data;
      if (r_kind == KLoad) begin
        m_rdy = 1'b1;
      end else begin
        check($sformatf("r%0d_maddr", n), 32'(o_maddr), 32'(m_a));
        check($sformatf("r%0d_we", n), 32'(o_we), 32'(r_kind == KWrite));
        check($sformatf("r%0d_cycles", n), 32'(o_cycles),
              32'((r_delay < 0) ? TO : r_delay + 1));
        if (r_kind == KWrite) check($sformatf("r%0d_wdata", n), o_wdata, m_wd);
        if (r_delay < 0) begin
          m_err = 1'b1;
          m_rdy = 1'b0;
        end else begin
          m_d   = (r_kind == KWrite) ? m_wd : r_rdata;
          m_rdy = 1'b1;
        end
        m_a = m_a + 8'd1;
      end
      check($sformatf("r%0d_a", n), 32'(mon_a), 32'(m_a));
      check($sformatf("r%0d_d", n), mon_d, m_d);
      check($sformatf("r%0d_rdy", n), 32'(monitor_ready), 32'(m_rdy));
      check($sformatf("r%0d_err", n), 32'(monitor_error), 32'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_ocimem_ctrl.md
Name: dbg_ocimem_ctrl

Overview:
- Sysclk-domain consumer of the debug-slave command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo word.
- Turns host JTAG commands into word reads and writes on an on-chip debug memory port.
- Maintains the monitor address and data registers (MonAReg, MonDReg) and reports monitor_ready and monitor_error back to the TCK-side capture logic.

Parameters:
- ADDR_W, 8: debug-memory word-address width.
- TIMEOUT, 255: cycles to wait for mem_ack before aborting; 8-bit counter, legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- jdo  in  38  command payload, held stable for at least 1 cycle after a strobe.
- take_action_ocimem_a  in  1  1-cycle strobe: load address, optional read.
- take_action_ocimem_b  in  1  1-cycle strobe: write data at current address.
- take_no_action_ocimem_a  in  1  1-cycle strobe: read at current address (streaming).
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  1-cycle completion pulse.
- mem_rdata  in  32  read data, valid with mem_ack on reads.
- MonAReg  out  ADDR_W  current monitor address.
- MonDReg  out  32  last read data or last written data.
- monitor_ready  out  1  last command completed.
- monitor_error  out  1  sticky error: timeout or dropped command.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, active-high): all outputs 0, FSM to IDLE, timeout counter 0. Reset mid-access drops mem_req on the next edge with no retry; a late mem_ack arriving in IDLE is ignored.
- jdo decode:
  - take_action_ocimem_a: MonAReg <= jdo[ADDR_W+1:2]. If jdo[35]=1, issue a read at the new address.
  - take_action_ocimem_b: mem_wdata <= jdo[34:3]; issue a write at MonAReg.
  - take_no_action_ocimem_a: issue a read at MonAReg.
- Strobe priority when several are active in one cycle: b > action_a > no_action_a. Lower-priority strobes are discarded and monitor_error is set.
- FSM states: IDLE, RD_REQ, WR_REQ, DONE.
  - IDLE + read command -> RD_REQ. IDLE + write command -> WR_REQ. monitor_ready <= 0 on the same edge.
  - RD_REQ / WR_REQ: mem_req=1, mem_addr=MonAReg, mem_we=(WR_REQ). Counter increments each cycle.
  - On mem_ack: a read loads MonDReg <= mem_rdata; a write loads MonDReg <= mem_wdata. Then -> DONE.
  - If the counter reaches TIMEOUT with no mem_ack: deassert mem_req, set monitor_error, -> DONE with MonDReg unchanged.
  - DONE (1 cycle): MonAReg <= MonAReg+1, wrapping modulo 2^ADDR_W with no flag. monitor_ready <= 1, except after a timeout, where it stays 0. -> IDLE.
  - A successful address-load-only command (jdo[35]=0) completes in IDLE: no memory access, no increment, monitor_ready <= 1 on the next edge.
- Latency: strobe at edge N gives mem_req high from N+1. mem_ack at edge M gives MonDReg valid and FSM in DONE after M. monitor_ready is high after M+1.
- Any strobe arriving while busy=1 is dropped, sets monitor_error, and does not change FSM or registers.
- monitor_error clears only on reset, or on take_action_ocimem_a with jdo[36]=1 (error-clear bit), applied before any new error on the same edge.
- mem_addr and mem_we are stable while mem_req=1.

Decomposition:
- Package dbg_ocimem_pkg holds:
  - the state enum;
  - jdo field constants: JDO_RD_BIT=35, JDO_CLR_BIT=36, JDO_DATA_LSB=3, JDO_ADDR_LSB=2;
  - TIMEOUT width.
- One sub-module, dbg_cmd_arbiter: a combinational priority and drop detector over the three strobes plus busy. It outputs a one-hot command and a drop flag.
- FSM and datapath stay in the top module.

Test Plan:
- Address load + read: action_a with jdo[9:2]=0x10 and jdo[35]=1; mem_ack after 3 cycles with rdata 0xDEADBEEF -> mem_addr=0x10, MonDReg=0xDEADBEEF, MonAReg=0x11, monitor_ready=1, error=0.
- Write: action_b with jdo[34:3]=0x12345678 at MonAReg=0x11 -> mem_we=1, mem_wdata=0x12345678, MonAReg=0x12 after DONE.
- Streaming wrap: MonAReg=0xFF, no_action_a read acked -> MonAReg=0x00, no error.
- Timeout: no mem_ack with TIMEOUT=4 -> mem_req drops after 4 cycles, monitor_error=1, monitor_ready=0, MonDReg unchanged. Then action_a with jdo[36]=1 clears error.
- Collision: action_b and no_action_a in the same cycle -> write only, monitor_error=1. A strobe during busy -> dropped, error=1, access completes normally.
- Reset mid-read: reset asserted while in RD_REQ -> next edge mem_req=0, all outputs 0. A late mem_ack is ignored and MonDReg stays 0.
